mouse_receiver: RTL and testbench

PS/2 device-to-host receive path for the mouse interface; the counterpart of the host-to-device transmitter. Samples the open-collector clock/data lines driven by the mouse and deframes 11-bit frames (start, 8 data LSB-first, odd parity, stop). Delivers each byte with an error code and a one-cycle ready strobe to the mouse master state machine. Receive-only: never drives either line.

---
 rtl/mouse_receiver.sv | 133 +++++++++++++
 tb/tb_mouse_receiver.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mouse_receiver.sv
// mouse_receiver: PS/2 device-to-host frame receiver (start, 8 data LSB-first, odd parity, stop).
// Optional MOUSE_RX_DEGLITCH_EN: clock falling edge needs two low samples, adding 2 cycles latency.
module mouse_receiver #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CTR_W = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_MOUSE_IN,
  input  logic       DATA_MOUSE_IN,
  input  logic       READ_ENABLE,
  output logic [7:0] BYTE_READ,
  output logic [1:0] BYTE_ERROR_CODE,
  output logic       BYTE_READY
);
  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, DONE} state_t;
  state_t state, state_n;
  logic [1:0] clk_sync, data_sync;
  logic fe, din;
  logic [2:0] bit_cnt, bit_n;
  logic [CTR_W-1:0] tmo, tmo_n;
  logic [7:0] sr, sr_n, byte_n;
  logic par_err, par_n, stop_err, stop_n, ready_n;
  logic [1:0] code_n;
  // Lines idle high, so synchronisers reset to 1 to avoid a false edge after reset
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], CLK_MOUSE_IN};
      data_sync <= {data_sync[0], DATA_MOUSE_IN};
    end
`ifdef MOUSE_RX_DEGLITCH_EN
  logic [2:0] clk_hist;
  logic [1:0] data_dly;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      clk_hist <= 3'b111;
      data_dly <= 2'b11;
    end else begin
      clk_hist <= {clk_hist[1:0], clk_sync[1]};
      data_dly <= {data_dly[0], data_sync[1]};
    end
  assign fe  = clk_hist == 3'b100;
  assign din = data_dly[1];
`else
  logic clk_prev;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) clk_prev <= 1'b1;
    else clk_prev <= clk_sync[1];
  assign fe  = clk_prev & ~clk_sync[1];
  assign din = data_sync[1];
`endif
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state           <= IDLE;
      bit_cnt         <= '0;
      tmo             <= '0;
      sr              <= '0;
      par_err         <= 1'b0;
      stop_err        <= 1'b0;
      BYTE_READ       <= '0;
      BYTE_ERROR_CODE <= '0;
      BYTE_READY      <= 1'b0;
    end else begin
      state           <= state_n;
      bit_cnt         <= bit_n;
      tmo             <= tmo_n;
      sr              <= sr_n;
      par_err         <= par_n;
      stop_err        <= stop_n;
      BYTE_READ       <= byte_n;
      BYTE_ERROR_CODE <= code_n;
      BYTE_READY      <= ready_n;
    end
  always_comb begin
    state_n = state;
    bit_n   = bit_cnt;
    tmo_n   = tmo;
    sr_n    = sr;
    par_n   = par_err;
    stop_n  = stop_err;
    byte_n  = BYTE_READ;
    code_n  = BYTE_ERROR_CODE;
    ready_n = 1'b0;
    if (state != IDLE && !READ_ENABLE) begin
      state_n = IDLE;
      bit_n   = '0;
      tmo_n   = '0;
    end else
      case (state)
        IDLE: begin
          bit_n = '0;
          tmo_n = '0;
          if (fe && !din && READ_ENABLE) state_n = DATA;
        end
        DONE: begin
          byte_n  = sr;
          code_n  = {stop_err, par_err};
          ready_n = 1'b1;
          state_n = IDLE;
        end
        default:
          if (fe) begin
            tmo_n = '0;
            case (state)
              DATA: begin
                sr_n[bit_cnt] = din;
                bit_n = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                  state_n = PARITY;
                  bit_n   = '0;
                end
              end
              PARITY: begin
                par_n   = din != ~^sr;
                state_n = STOP;
              end
              default: begin
                stop_n  = ~din;
                state_n = DONE;
              end
            endcase
          end else if (tmo == CTR_W'(TIMEOUT_CYCLES)) begin
            state_n = IDLE;
            bit_n   = '0;
            tmo_n   = '0;
          end else
            tmo_n = tmo + 1'b1;
      endcase
  end
endmodule

// File: tb/tb_mouse_receiver.sv
// tb_mouse_receiver: scoreboard bench driving PS/2 frames into mouse_receiver.
module tb_mouse_receiver;
  localparam int H = 20;
  typedef struct {
    logic [7:0] b;
    logic [1:0] c;
    bit corrupt;
  } exp_t;
  logic CLK = 0, RESET = 1, mclk = 1, mdata = 1, READ_ENABLE = 1;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic BYTE_READY;
  exp_t q[$];
  int checks = 0, failures = 0, unexpected = 0;
  mouse_receiver dut (
    .CLK(CLK), .RESET(RESET), .CLK_MOUSE_IN(mclk), .DATA_MOUSE_IN(mdata),
    .READ_ENABLE(READ_ENABLE), .BYTE_READ(BYTE_READ),
    .BYTE_ERROR_CODE(BYTE_ERROR_CODE), .BYTE_READY(BYTE_READY)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
    end
  endtask
  always @(negedge CLK)
    if (BYTE_READY === 1'b1) begin : mon
      exp_t e;
      if (q.size() == 0) begin
        unexpected++;
        $display("FAIL unexpected_pulse obs=%0h", BYTE_READ);
      end else begin
        e = q.pop_front();
        if (e.corrupt) check("glitch_corrupt", 32'((BYTE_READ != 8'hC3) || (BYTE_ERROR_CODE != 2'b00)), 1);
        else begin
          check("byte", BYTE_READ, e.b);
          check("code", BYTE_ERROR_CODE, e.c);
        end
      end
    end
  task automatic expect_byte(input logic [7:0] b, input logic [1:0] c, input bit corrupt);
    exp_t e;
    e.b = b;
    e.c = c;
    e.corrupt = corrupt;
    q.push_back(e);
  endtask
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp, input int nbits, input int glitch);
    logic [10:0] f;
    f = {stp, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      mdata = f[i];
      if (i == glitch) begin
        repeat (H / 2) @(negedge CLK);
        mclk = 0;
        @(negedge CLK);
        mclk = 1;
        repeat (H / 2) @(negedge CLK);
      end else repeat (H) @(negedge CLK);
      mclk = 0;
      repeat (H) @(negedge CLK);
      mclk = 1;
    end
    repeat (H) @(negedge CLK);
    mdata = 1;
  endtask
  task automatic drain(input string tag);
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge CLK);
    check(tag, q.size(), 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge CLK);
    check("rst_byte", BYTE_READ, 8'h00);
    check("rst_code", BYTE_ERROR_CODE, 2'b00);
    check("rst_ready", BYTE_READY, 1'b0);
    RESET = 0;
    repeat (5) @(negedge CLK);
    expect_byte(8'hFA, 2'b00, 0);
    send_frame(8'hFA, 1, 1, 11, -1);
    drain("drain_fa");
    expect_byte(8'h08, 2'b01, 0);
    send_frame(8'h08, 1, 1, 11, -1);
    drain("drain_par");
    expect_byte(8'h08, 2'b10, 0);
    send_frame(8'h08, 0, 0, 11, -1);
    drain("drain_stop");
    send_frame(8'h00, 0, 0, 5, -1);
    repeat (60000) @(negedge CLK);
    expect_byte(8'hAA, 2'b00, 0);
    send_frame(8'hAA, 1, 1, 11, -1);
    drain("drain_tmo");
    READ_ENABLE = 0;
    send_frame(8'h55, 1, 1, 11, -1);
    repeat (20) @(negedge CLK);
    check("hold_byte", BYTE_READ, 8'hAA);
    READ_ENABLE = 1;
    repeat (5) @(negedge CLK);
    expect_byte(8'h55, 2'b00, 0);
    send_frame(8'h55, 1, 1, 11, -1);
    drain("drain_55");
    send_frame(8'hFF, 0, 1, 6, -1);
    RESET = 1;
    #1;
    check("mid_rst_byte", BYTE_READ, 8'h00);
    check("mid_rst_code", BYTE_ERROR_CODE, 2'b00);
    check("mid_rst_ready", BYTE_READY, 1'b0);
    repeat (3) @(negedge CLK);
    RESET = 0;
    repeat (5) @(negedge CLK);
    expect_byte(8'h00, 2'b00, 0);
    send_frame(8'h00, 1, 1, 11, -1);
    drain("drain_00");
`ifdef MOUSE_RX_DEGLITCH_EN
    expect_byte(8'hC3, 2'b00, 0);
`else
    expect_byte(8'hC3, 2'b00, 1);
`endif
    send_frame(8'hC3, 1, 1, 11, 3);
    drain("drain_glitch");
    repeat (100) @(negedge CLK);
    check("no_extra_pulse", unexpected, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
